// File: rtl/digit_ring_pkg.sv
// Shared definitions for the digit_ring block.
//   action_e : counter/register operation selector (hold, advance, load, clear)
//   state_e  : control FSM states (idle, timed auto-rotate)
//   clog2    : ceiling log2, used to size index and counter fields
package digit_ring_pkg;

    typedef enum logic [1:0] {
        ACT_NONE,
        ACT_INCR,
        ACT_LOAD,
        ACT_CLR
    } action_e;

    typedef enum logic {
        ST_IDLE,
        ST_AUTO
    } state_e;

    localparam int unsigned STEP_W = 16;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/digit_ring_tick.sv
// Period counter for the auto-rotate timer.
//   clk, async_nreset : clock, asynchronous active-low reset
//   en                : count while high
//   clr               : return the count to 0 (overrides en)
//   tick              : one-cycle pulse in the last cycle of each TICK_CYCLES period
module digit_ring_tick
    import digit_ring_pkg::*;
#(
    parameter int unsigned TICK_CYCLES = 50000000
) (
    input  logic clk,
    input  logic async_nreset,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CNT_W = clog2(TICK_CYCLES);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_CYCLES - 1);

    action_e          op;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;

    always_comb begin
        op    = clr ? ACT_CLR : (en ? ACT_INCR : ACT_NONE);
        tick  = (op == ACT_INCR) && (cnt_q == LAST);
        cnt_d = cnt_q;
        case (op)
            ACT_CLR:  cnt_d = '0;
            ACT_INCR: cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
            default:  cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge async_nreset) begin
        if (!async_nreset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/digit_ring.sv
// Digit shift/rotate bank: DEPTH entries of WIDTH bits.
//   clk, async_nreset : clock, asynchronous active-low reset
//   sw                : entry switches; highest set bit k encodes SW_BASE+k
//   btn_push          : push encoded switch value into entry[0]
//   btn_rot           : rotate once in direction dir
//   btn_auto          : start a timed auto-rotate run, or abort one in progress
//   dir               : 0 rotates toward index 0, 1 toward index DEPTH-1
//   rd_idx / rd_data  : random read port (out-of-range indices read 0)
//   head_data         : entry[0]
//   led_match         : switches still equal the word captured by the last push
//   busy, steps_left  : auto run active, rotations remaining
module digit_ring
    import digit_ring_pkg::*;
#(
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned WIDTH       = 4,
    parameter int unsigned NSW         = 7,
    parameter int unsigned SW_BASE     = 3,
    parameter int unsigned TICK_CYCLES = 50000000,
    parameter int unsigned AUTO_STEPS  = 15
) (
    input  logic                      clk,
    input  logic                      async_nreset,
    input  logic [NSW-1:0]            sw,
    input  logic                      btn_push,
    input  logic                      btn_rot,
    input  logic                      btn_auto,
    input  logic                      dir,
    input  logic [clog2(DEPTH)-1:0]   rd_idx,
    output logic [WIDTH-1:0]          rd_data,
    output logic [WIDTH-1:0]          head_data,
    output logic                      led_match,
    output logic                      busy,
    output logic [STEP_W-1:0]         steps_left
);

    localparam int unsigned IDX_W    = clog2(DEPTH);
    localparam int unsigned RD_SLOTS = 1 << IDX_W;

    logic [WIDTH-1:0]  entry_d [DEPTH];
    logic [WIDTH-1:0]  entry_q [DEPTH];
    state_e            state_d, state_q;
    logic [STEP_W-1:0] steps_d, steps_q;
    logic              auto_dir_d, auto_dir_q;
    logic [NSW-1:0]    sw_cap_d, sw_cap_q;
    logic              match_d, match_q;
    logic              push_prev_d, push_prev_q;
    logic              rot_prev_d, rot_prev_q;
    logic              auto_prev_d, auto_prev_q;

    logic              press_push, press_rot, press_auto;
    logic              do_push, do_rot, rot_dir;
    logic [WIDTH-1:0]  push_val;
    action_e           steps_op;
    logic              tick;
    logic              tick_clr;
    logic [WIDTH-1:0]  rd_tbl [RD_SLOTS];

    digit_ring_tick #(
        .TICK_CYCLES (TICK_CYCLES)
    ) u_tick (
        .clk          (clk),
        .async_nreset (async_nreset),
        .en           (state_q == ST_AUTO),
        .clr          (tick_clr),
        .tick         (tick)
    );

    always_comb begin
        press_push  = btn_push & ~push_prev_q;
        press_rot   = btn_rot  & ~rot_prev_q;
        press_auto  = btn_auto & ~auto_prev_q;
        push_prev_d = btn_push;
        rot_prev_d  = btn_rot;
        auto_prev_d = btn_auto;

        // Ascending scan so the highest set switch overwrites lower ones.
        push_val = '0;
        for (int unsigned k = 0; k < NSW; k++) begin
            if (sw[k]) begin
                push_val = WIDTH'(SW_BASE + k);
            end
        end

        state_d    = state_q;
        auto_dir_d = auto_dir_q;
        do_push    = 1'b0;
        do_rot     = 1'b0;
        rot_dir    = dir;
        steps_op   = ACT_NONE;
        // Clearing in IDLE is harmless; in AUTO this press is the abort.
        tick_clr   = press_auto;

        unique case (state_q)
            ST_IDLE: begin
                // A push press with sw=0 still outranks rot/auto that cycle.
                if (press_push) begin
                    do_push = (sw != '0);
                end else if (press_rot) begin
                    do_rot = 1'b1;
                end else if (press_auto) begin
                    state_d    = ST_AUTO;
                    auto_dir_d = dir;
                    steps_op   = ACT_LOAD;
                end
            end
            ST_AUTO: begin
                rot_dir = auto_dir_q;
                // Abort outranks a coincident tick: no rotation that cycle.
                if (press_auto) begin
                    state_d  = ST_IDLE;
                    steps_op = ACT_CLR;
                end else if (tick) begin
                    do_rot   = 1'b1;
                    steps_op = ACT_INCR;
                    if (steps_q == STEP_W'(1)) begin
                        state_d = ST_IDLE;
                    end
                end
            end
        endcase

        // ACT_INCR advances the run, which counts steps_left down.
        case (steps_op)
            ACT_LOAD: steps_d = STEP_W'(AUTO_STEPS);
            ACT_CLR:  steps_d = '0;
            ACT_INCR: steps_d = steps_q - 1'b1;
            default:  steps_d = steps_q;
        endcase

        sw_cap_d = sw_cap_q;
        match_d  = match_q && (sw == sw_cap_q);
        entry_d  = entry_q;
        if (do_push) begin
            for (int unsigned i = 1; i < DEPTH; i++) begin
                entry_d[i] = entry_q[i-1];
            end
            entry_d[0] = push_val;
            sw_cap_d   = sw;
            match_d    = 1'b1;
        end else if (do_rot) begin
            if (!rot_dir) begin
                for (int unsigned i = 0; i < DEPTH - 1; i++) begin
                    entry_d[i] = entry_q[i+1];
                end
                entry_d[DEPTH-1] = entry_q[0];
            end else begin
                for (int unsigned i = 1; i < DEPTH; i++) begin
                    entry_d[i] = entry_q[i-1];
                end
                entry_d[0] = entry_q[DEPTH-1];
            end
        end
    end

    // Read table padded to a power of two; unused slots read 0.
    always_comb begin
        for (int unsigned i = 0; i < RD_SLOTS; i++) begin
            rd_tbl[i] = '0;
        end
        for (int unsigned i = 0; i < DEPTH; i++) begin
            rd_tbl[i] = entry_q[i];
        end
    end

    always_ff @(posedge clk or negedge async_nreset) begin
        if (!async_nreset) begin
            entry_q     <= '{default: '0};
            state_q     <= ST_IDLE;
            steps_q     <= '0;
            auto_dir_q  <= 1'b0;
            sw_cap_q    <= '0;
            match_q     <= 1'b0;
            push_prev_q <= 1'b0;
            rot_prev_q  <= 1'b0;
            auto_prev_q <= 1'b0;
        end else begin
            entry_q     <= entry_d;
            state_q     <= state_d;
            steps_q     <= steps_d;
            auto_dir_q  <= auto_dir_d;
            sw_cap_q    <= sw_cap_d;
            match_q     <= match_d;
            push_prev_q <= push_prev_d;
            rot_prev_q  <= rot_prev_d;
            auto_prev_q <= auto_prev_d;
        end
    end

    assign rd_data    = rd_tbl[rd_idx];
    assign head_data  = entry_q[0];
    assign led_match  = match_q;
    assign busy       = (state_q == ST_AUTO);
    assign steps_left = steps_q;

endmodule

// File: tb/tb_digit_ring.sv
// Self-checking bench for digit_ring with a small behavioural model.
module tb_digit_ring;

    localparam int DEPTH = 4;
    localparam int WIDTH = 4;
    localparam int NSW   = 7;
    localparam int BASE  = 3;
    localparam int TICKS = 4;
    localparam int STEPS = 3;

    logic             clk;
    logic             async_nreset;
    logic [NSW-1:0]   sw;
    logic             btn_push, btn_rot, btn_auto, dir;
    logic [1:0]       rd_idx;
    logic [WIDTH-1:0] rd_data, head_data;
    logic             led_match, busy;
    logic [15:0]      steps_left;

    digit_ring #(
        .DEPTH       (DEPTH),
        .WIDTH       (WIDTH),
        .NSW         (NSW),
        .SW_BASE     (BASE),
        .TICK_CYCLES (TICKS),
        .AUTO_STEPS  (STEPS)
    ) dut (
        .clk          (clk),
        .async_nreset (async_nreset),
        .sw           (sw),
        .btn_push     (btn_push),
        .btn_rot      (btn_rot),
        .btn_auto     (btn_auto),
        .dir          (dir),
        .rd_idx       (rd_idx),
        .rd_data      (rd_data),
        .head_data    (head_data),
        .led_match    (led_match),
        .busy         (busy),
        .steps_left   (steps_left)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total  = 0;
    int passed = 0;

    // Model state: array contents, push capture, auto run bookkeeping.
    int       m [DEPTH];
    logic [NSW-1:0] mcap;
    bit       mled, mbusy, mdir;
    int       msteps, melapsed;
    bit       prev_p, prev_r, prev_a;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total = total + 1;
        assert (got === exp) passed = passed + 1;
        else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic int enc(input logic [NSW-1:0] s);
        int v;
        v = 0;
        for (int k = 0; k < NSW; k++) if (s[k]) v = (BASE + k) % (1 << WIDTH);
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m[i] = 0;
        mcap = '0; mled = 0; mbusy = 0; mdir = 0;
        msteps = 0; melapsed = 0;
        prev_p = 0; prev_r = 0; prev_a = 0;
    endtask

    task automatic model_rot(input bit d);
        int t;
        if (!d) begin
            t = m[0];
            for (int i = 0; i < DEPTH - 1; i++) m[i] = m[i+1];
            m[DEPTH-1] = t;
        end else begin
            t = m[DEPTH-1];
            for (int i = DEPTH - 1; i > 0; i--) m[i] = m[i-1];
            m[0] = t;
        end
    endtask

    task automatic model_clock(input bit p, input bit r, input bit a, input bit d,
                               input logic [NSW-1:0] s);
        bit pp, pr, pa, pushed;
        pp = p && !prev_p;
        pr = r && !prev_r;
        pa = a && !prev_a;
        pushed = 0;
        if (!mbusy) begin
            if (pp) begin
                if (s != 0) begin
                    for (int i = DEPTH - 1; i > 0; i--) m[i] = m[i-1];
                    m[0] = enc(s);
                    mcap = s;
                    mled = 1;
                    pushed = 1;
                end
            end else if (pr) begin
                model_rot(d);
            end else if (pa) begin
                mbusy = 1; msteps = STEPS; mdir = d; melapsed = 0;
            end
        end else begin
            if (pa) begin
                mbusy = 0; msteps = 0;
            end else begin
                melapsed++;
                if (melapsed == TICKS) begin
                    melapsed = 0;
                    model_rot(mdir);
                    msteps--;
                    if (msteps == 0) mbusy = 0;
                end
            end
        end
        if (!pushed) mled = mled && (s == mcap);
        prev_p = p; prev_r = r; prev_a = a;
    endtask

    task automatic check_outputs();
        chk("head", 16'(head_data), 16'(m[0]));
        chk("rd",   16'(rd_data),   16'(m[rd_idx]));
        chk("led",  16'(led_match), 16'(mled));
        chk("busy", 16'(busy),      16'(mbusy));
        chk("steps", steps_left,    16'(msteps));
    endtask

    task automatic peek_all();
        logic [1:0] save;
        save = rd_idx;
        for (int i = 0; i < DEPTH; i++) begin
            rd_idx = 2'(i);
            #1;
            chk("peek", 16'(rd_data), 16'(m[i]));
        end
        rd_idx = save;
    endtask

    task automatic step(input bit p, input bit r, input bit a, input bit d,
                        input logic [NSW-1:0] s, input logic [1:0] idx);
        btn_push = p; btn_rot = r; btn_auto = a; dir = d; sw = s; rd_idx = idx;
        @(posedge clk);
        model_clock(p, r, a, d, s);
        #1;
        check_outputs();
    endtask

    task automatic idle(input int n, input logic [NSW-1:0] s);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, s, 2'(i));
    endtask

    initial begin
        logic [NSW-1:0] cur_sw;
        async_nreset = 1'b0;
        sw = '0; btn_push = 0; btn_rot = 0; btn_auto = 0; dir = 0; rd_idx = '0;
        model_reset();
        #12;
        check_outputs();
        peek_all();
        async_nreset = 1'b1;
        idle(2, 7'b0);

        // Push 7 then 3; a change of sw drops led_match on the next edge.
        step(1, 0, 0, 0, 7'b0010010, 0);
        idle(1, 7'b0010010);
        step(1, 0, 0, 0, 7'b0000001, 1);
        idle(1, 7'b0000001);
        chk("head_is_3", 16'(head_data), 16'd3);
        rd_idx = 2'd1; #1;
        chk("entry1_is_7", 16'(rd_data), 16'd7);
        chk("led_set", 16'(led_match), 16'd1);
        idle(1, 7'b0000011);
        chk("led_clear", 16'(led_match), 16'd0);

        // Load {4,5,6,7}.
        step(1, 0, 0, 0, 7'b0010000, 0); idle(1, 7'b0010000);
        step(1, 0, 0, 0, 7'b0001000, 0); idle(1, 7'b0001000);
        step(1, 0, 0, 0, 7'b0000100, 0); idle(1, 7'b0000100);
        step(1, 0, 0, 0, 7'b0000010, 0); idle(1, 7'b0000010);
        peek_all();

        step(0, 1, 0, 0, 7'b0000010, 0); idle(1, 7'b0000010);
        chk("rot0_head", 16'(head_data), 16'd5);
        peek_all();
        step(0, 1, 0, 1, 7'b0000010, 0); idle(1, 7'b0000010);
        chk("rot1_head", 16'(head_data), 16'd4);
        for (int i = 0; i < 10; i++) step(0, 1, 0, 0, 7'b0000010, 2'(i));
        idle(1, 7'b0000010);
        peek_all();

        // Push with sw=0, then push+rot together.
        step(1, 0, 0, 0, 7'b0, 0); idle(1, 7'b0);
        peek_all();
        step(1, 1, 0, 0, 7'b0000001, 0); idle(1, 7'b0000001);
        peek_all();

        // Auto run, dir=0, with ignored pushes and a dir change mid-run.
        step(0, 0, 1, 0, 7'b0000001, 0);
        chk("auto_busy", 16'(busy), 16'd1);
        chk("auto_steps", steps_left, 16'd3);
        idle(1, 7'b0000001);
        step(1, 0, 0, 1, 7'b1000000, 1);
        step(0, 0, 0, 1, 7'b1000000, 2);
        step(1, 0, 0, 1, 7'b1000000, 3);
        idle(12, 7'b1000000);
        chk("auto_done", 16'(busy), 16'd0);
        peek_all();

        // Abort landing on the first tick wrap.
        step(0, 0, 1, 0, 7'b0, 0);
        idle(3, 7'b0);
        step(0, 0, 1, 0, 7'b0, 0);
        chk("abort_busy", 16'(busy), 16'd0);
        chk("abort_steps", steps_left, 16'd0);
        idle(6, 7'b0);
        peek_all();

        // Randomised phase.
        cur_sw = 7'b0000100;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 5) == 0) cur_sw = 7'($urandom);
            step($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 9) == 0, 1'($urandom), cur_sw, 2'($urandom));
        end
        idle(16, cur_sw);
        peek_all();

        // Reset asserted in the middle of an auto run.
        step(0, 0, 1, 1, 7'b0, 0);
        idle(5, 7'b0);
        async_nreset = 1'b0;
        model_reset();
        #1;
        check_outputs();
        chk("rst_busy", 16'(busy), 16'd0);
        peek_all();
        async_nreset = 1'b1;
        step(0, 0, 0, 0, 7'b0, 3);
        chk("rst_rd3", 16'(rd_data), 16'd0);
        idle(6, 7'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
